// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: last-winner state encoding and mux-select constants shared with select users.
package wb_port_arbiter_pkg;
   localparam logic ST_LAST_A = 1'b1;
   localparam logic ST_LAST_B = 1'b0;
   localparam logic SEL_A     = 1'b1;
   localparam logic SEL_B     = 1'b0;
endpackage

// File: rtl/wb_port_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant with a last-winner flop; grants are one-hot or zero.
module rr_arb2
   import wb_port_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic stall,
   output logic gnt_a,
   output logic gnt_b,
   output logic state
);
   logic go;

   assign go    = !rst && !stall;
   assign gnt_a = go && req_a && (!req_b || state == ST_LAST_B);
   assign gnt_b = go && req_b && (!req_a || state == ST_LAST_A);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        state <= ST_LAST_B;
      else if (gnt_a) state <= ST_LAST_A;
      else if (gnt_b) state <= ST_LAST_B;
   end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one register-file write port between A (ALU) and B (load data),
// registering the winner into a single write stage and counting contended cycles.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] data_a,
   output logic              gnt_a,
   input  logic              req_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] data_b,
   output logic              gnt_b,
   input  logic              stall,
   output logic              sel,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [CNT_W-1:0]  contention
);
   logic state;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_a (req_a),
      .req_b (req_b),
      .stall (stall),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b),
      .state (state)
   );

   // with no grant, keep pointing at the last winner so the mux does not toggle
   assign sel = (gnt_a || gnt_b) ? (gnt_a ? SEL_A : SEL_B)
                                 : (state == ST_LAST_A ? SEL_A : SEL_B);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if (!stall) begin
         wr_en <= gnt_a || gnt_b;
         if (gnt_a) begin
            wr_addr <= addr_a;
            wr_data <= data_a;
         end else if (gnt_b) begin
            wr_addr <= addr_b;
            wr_data <= data_b;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                   contention <= '0;
      else if (req_a && req_b && !stall && contention != '1)     contention <= contention + 1'b1;
   end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed checks of grant order, write stage, stall, reset and counter saturation.
module tb_wb_port_arbiter;
   logic        clk = 1'b0;
   logic        rst, req_a, req_b, stall;
   logic [4:0]  addr_a, addr_b;
   logic [31:0] data_a, data_b;
   logic        gnt_a, gnt_b, sel, wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [7:0]  contention;
   logic        s_gnt_a, s_gnt_b, s_sel, s_wr_en;
   logic [4:0]  s_wr_addr;
   logic [31:0] s_wr_data;
   logic [1:0]  s_contention;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   wb_port_arbiter dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .gnt_a(gnt_a),
      .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .gnt_b(gnt_b),
      .stall(stall), .sel(sel), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .contention(contention)
   );

   wb_port_arbiter #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst),
      .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .gnt_a(s_gnt_a),
      .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .gnt_b(s_gnt_b),
      .stall(stall), .sel(s_sel), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
      .wr_data(s_wr_data), .contention(s_contention)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0;
      req_a = 1'b1; addr_a = 5'd0; data_a = 32'h0;
      req_b = 1'b0; addr_b = 5'd0; data_b = 32'h0;
      step();
      check("rst_gnt_a", gnt_a, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_contention", contention, 0);
      req_a = 1'b0;
      rst = 1'b0;
      // solo A
      req_a = 1'b1; addr_a = 5'd3; data_a = 32'hDEADBEEF;
      #1;
      check("solo_gnt_a", gnt_a, 1);
      check("solo_gnt_b", gnt_b, 0);
      check("solo_sel", sel, 1);
      step();
      req_a = 1'b0;
      check("solo_wr_en", wr_en, 1);
      check("solo_wr_addr", wr_addr, 3);
      check("solo_wr_data", wr_data, 32'hDEADBEEF);
      // idle after write
      #1;
      check("idle_sel", sel, 1);
      check("idle_gnt_a", gnt_a, 0);
      step();
      check("idle_wr_en", wr_en, 0);
      check("idle_wr_addr", wr_addr, 3);
      check("idle_wr_data", wr_data, 32'hDEADBEEF);
      // solo B to address 0, then reset mid-write
      req_b = 1'b1; addr_b = 5'd0; data_b = 32'h55;
      #1;
      check("b_gnt_b", gnt_b, 1);
      check("b_sel", sel, 0);
      step();
      req_b = 1'b0;
      check("b_wr_en", wr_en, 1);
      check("b_wr_addr0", wr_addr, 0);
      check("b_wr_data", wr_data, 32'h55);
      #1;
      check("b_idle_sel", sel, 0);
      req_a = 1'b1; addr_a = 5'd9; data_a = 32'h99;
      step();
      req_a = 1'b0;
      check("pre_rst_wr_en", wr_en, 1);
      #2 rst = 1'b1;
      #1;
      check("async_wr_en", wr_en, 0);
      check("async_wr_addr", wr_addr, 0);
      check("async_wr_data", wr_data, 0);
      check("async_sel", sel, 0);
      step();
      rst = 1'b0;
      // both requesting for 6 cycles from reset: A,B,A,B,A,B
      req_a = 1'b1; addr_a = 5'd1; data_a = 32'hA1;
      req_b = 1'b1; addr_b = 5'd2; data_b = 32'hB2;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("both_gnt_a", gnt_a, (i % 2 == 0));
         check("both_gnt_b", gnt_b, (i % 2 == 1));
         check("both_sel", sel, (i % 2 == 0));
         step();
         check("both_wr_en", wr_en, 1);
         check("both_wr_addr", wr_addr, (i % 2 == 0) ? 1 : 2);
         check("both_wr_data", wr_data, (i % 2 == 0) ? 32'hA1 : 32'hB2);
         check("both_contention", contention, i + 1);
         check("sat_contention", s_contention, (i < 3) ? i + 1 : 3);
      end
      // stall with both requesting: everything frozen
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_gnt_a", gnt_a, 0);
         check("stall_gnt_b", gnt_b, 0);
         step();
         check("stall_wr_en", wr_en, 1);
         check("stall_wr_addr", wr_addr, 2);
         check("stall_wr_data", wr_data, 32'hB2);
         check("stall_contention", contention, 6);
         check("stall_sat", s_contention, 3);
      end
      stall = 1'b0;
      #1;
      check("release_gnt_a", gnt_a, 1);
      check("release_gnt_b", gnt_b, 0);
      step();
      req_a = 1'b0; req_b = 1'b0;
      check("release_wr_addr", wr_addr, 1);
      check("release_contention", contention, 7);
      step();
      check("end_wr_en", wr_en, 0);
      check("end_wr_addr", wr_addr, 1);
      check("end_sel", sel, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
